// File: rtl/mux21_sel_arb.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// Grants are held until done or request drop, with bounded pre-emption when contended.
module mux21_sel_arb #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             done0,
   input  logic             done1,
   output logic             sel,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic [CNT_W-1:0] hold_cnt
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] G0   = 2'd1;
   localparam logic [1:0] G1   = 2'd2;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             last_served;
   logic             sel_next;
   logic [CNT_W-1:0] hold_next;
   logic             grant_entry;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req0 && req1)
               state_next = last_served ? G0 : G1;
            else if (req0)
               state_next = G0;
            else if (req1)
               state_next = G1;
            else
               state_next = IDLE;
         end
         G0: begin
            // Release outranks pre-emption; both lead to the same switch when req1 is up.
            if (done0 || !req0)
               state_next = req1 ? G1 : IDLE;
            else if (req1 && (hold_cnt == HOLD_LAST))
               state_next = G1;
            else
               state_next = G0;
         end
         G1: begin
            if (done1 || !req1)
               state_next = req0 ? G0 : IDLE;
            else if (req0 && (hold_cnt == HOLD_LAST))
               state_next = G0;
            else
               state_next = G1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      grant_entry = (state_next != state) && (state_next != IDLE);

      sel_next = sel;
      if (state_next == G0)
         sel_next = 1'b0;
      else if (state_next == G1)
         sel_next = 1'b1;

      if (state_next == IDLE || grant_entry)
         hold_next = '0;
      else if (hold_cnt == HOLD_LAST)
         hold_next = hold_cnt;
      else
         hold_next = hold_cnt + CNT_W'(1);
   end

   // Outputs are registered from the next-state decode so sel never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_served <= 1'b1;
         sel         <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         busy        <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         state    <= state_next;
         sel      <= sel_next;
         gnt0     <= (state_next == G0);
         gnt1     <= (state_next == G1);
         busy     <= (state_next != IDLE);
         hold_cnt <= hold_next;
         if (grant_entry)
            last_served <= (state_next == G1);
      end
   end

endmodule

// File: tb/tb_mux21_sel_arb.sv
// Directed bench for mux21_sel_arb: vector table for grant sequencing plus
// hand-written sequences for pre-emption, saturation and asynchronous reset.
module tb_mux21_sel_arb;

   logic       clk = 1'b1;
   logic       rst;
   logic       req0, req1, done0, done1;
   logic       sel, gnt0, gnt1, busy;
   logic [3:0] hold_cnt;

   int checks = 0;
   int errors = 0;

   mux21_sel_arb #(.MAX_HOLD(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .done0    (done0),
      .done1    (done1),
      .sel      (sel),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .busy     (busy),
      .hold_cnt (hold_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       r0;
      logic       r1;
      logic       d0;
      logic       d1;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [19];

   // Expected output word {gnt0, gnt1, sel, busy, hold_cnt}
   function automatic logic [7:0] e(input logic g0, input logic g1, input logic s, input int hc);
      logic [3:0] h;
      h = 4'(hc);
      return {g0, g1, s, g0 | g1, h};
   endfunction

   task automatic check(input string name, input logic [7:0] want);
      logic [7:0] got;
      got = {gnt0, gnt1, sel, busy, hold_cnt};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got g0g1/sel/busy/hc=%b required %b at %0t", name, got, want, $time);
      end else begin
         $display("check %s: %b at %0t", name, got, $time);
      end
   endtask

   task automatic step(input logic r0, input logic r1, input logic d0, input logic d1);
      @(negedge clk);
      req0  = r0;
      req1  = r1;
      done0 = d0;
      done1 = d1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((gnt0 && gnt1) || (busy !== (gnt0 | gnt1))) begin
            errors++;
            $display("FAIL excl: got gnt0=%b gnt1=%b busy=%b required exclusive grants and busy=gnt0|gnt1 at %0t",
                     gnt0, gnt1, busy, $time);
         end
      end
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(1, 0, 0, 0)};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(1, 0, 0, 1)};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(1, 0, 0, 2)};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, e(0, 1, 1, 0)};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(0, 1, 1, 1)};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(0, 1, 1, 2)};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, e(1, 0, 0, 0)};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(1, 0, 0, 1)};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, e(1, 0, 0, 2)};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, e(0, 1, 1, 0)};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, e(0, 0, 1, 0)};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, e(0, 0, 1, 0)};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, e(0, 0, 1, 0)};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, e(1, 0, 0, 0)};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, e(1, 0, 0, 1)};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, e(0, 0, 0, 0)};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, e(0, 1, 1, 0)};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, e(1, 0, 0, 0)};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, e(0, 0, 0, 0)};

      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;

      // Reset and single request
      #12 check("reset_state", e(0, 0, 0, 0));
      #3  rst = 1'b0;
      #7  req0 = 1'b1;
      @(posedge clk); #1;
      check("single_gnt0", e(1, 0, 0, 0));
      step(1, 0, 0, 0); check("single_hold", e(1, 0, 0, 1));
      step(1, 0, 1, 0); check("single_done", e(0, 0, 0, 0));
      step(0, 0, 0, 0); check("single_idle", e(0, 0, 0, 0));

      // Fresh reset so last_served favours source 0 for the tie
      @(negedge clk); rst = 1'b1; #1 rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Pre-emption: source 1 waits while source 0 holds without done
      step(1, 0, 0, 0); check("pre_cnt0", e(1, 0, 0, 0));
      for (int k = 1; k < 8; k++) begin
         step(1, 1, 0, 0); check($sformatf("pre_cnt%0d", k), e(1, 0, 0, k));
      end
      step(1, 1, 0, 0); check("pre_switch", e(0, 1, 1, 0));
      step(0, 0, 0, 0); check("pre_idle", e(0, 0, 1, 0));

      // No contention: source 1 alone, counter saturates
      for (int k = 0; k < 20; k++) begin
         step(0, 1, 0, 0); check($sformatf("solo%0d", k), e(0, 1, 1, (k > 7) ? 7 : k));
      end
      step(0, 0, 0, 0); check("solo_idle", e(0, 0, 1, 0));

      // Asynchronous reset mid-grant
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 0);
      end
      check("ar_pre", e(0, 1, 1, 3));
      #1 rst = 1'b1;
      #1 check("ar_async", e(0, 0, 0, 0));
      #1 rst = 1'b0;
      step(1, 1, 0, 0); check("ar_tie", e(1, 0, 0, 0));

      // Simultaneous release and pre-emption at hold_cnt = MAX_HOLD-1
      for (int k = 1; k < 8; k++) begin
         step(1, 1, 0, 0);
      end
      check("sim_cnt7", e(1, 0, 0, 7));
      step(1, 1, 1, 0); check("sim_switch", e(0, 1, 1, 0));
      step(1, 1, 0, 0); check("sim_stay", e(0, 1, 1, 1));
      step(0, 0, 0, 0); check("sim_idle", e(0, 0, 1, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
